rr_mux8: RTL and testbench

Parametrised N-channel, W-bit streaming multiplexer with registered output and valid/ready handshakes. It generalises the 8-to-1 bit mux into a word-wide channel selector with two modes:
- fixed select, where the `s` input chooses the channel;
- round-robin arbitration across all channels.

It sits between parallel producer channels and a single downstream consumer, and gives one transfer per cycle at one cycle latency.

---
 rtl/rr_mux8.sv | 127 ++++++++++++
 tb/tb_rr_mux8.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rr_mux8.sv
// rr_mux8: N-channel, W-bit streaming multiplexer with a registered output.
// Mode 0 forwards the channel picked by s; mode 1 arbitrates round-robin
// across all valid channels, starting after the last granted channel.
//
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset
//   mode     - 0: fixed select from s, 1: round-robin
//   s        - channel select (mode 0 only); s >= N grants nothing
//   d        - packed channel data, channel k at d[k*W +: W]
//   d_valid  - per-channel valid
//   d_ready  - per-channel ready, one-hot or zero
//   o        - registered output word
//   o_valid  - output register holds a word
//   o_ready  - downstream accepts the word
//   o_ch     - source channel index of o
module rr_mux8 #(
  parameter int N  = 8,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [SW-1:0]   s,
  input  logic [N*W-1:0]  d,
  input  logic [N-1:0]    d_valid,
  output logic [N-1:0]    d_ready,
  output logic [W-1:0]    o,
  output logic            o_valid,
  input  logic            o_ready,
  output logic [SW-1:0]   o_ch
);

  localparam int unsigned NU = N;

  logic [W-1:0]  o_q, o_d;
  logic [SW-1:0] ch_q, ch_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic          vld_q, vld_d;

  logic          load;
  logic          gnt_vld;
  logic [SW-1:0] gnt;
  logic [SW-1:0] idx;
  logic [W-1:0]  gnt_data;

  assign load = !vld_q || o_ready;

  // Grant selection. In round-robin mode the scan runs ptr+1 .. ptr+N
  // (modulo N); the first valid channel found wins, so ptr itself is
  // considered last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    idx     = '0;
    if (mode) begin
      for (int unsigned i = 1; i <= NU; i++) begin
        idx = SW'((32'(ptr_q) + i) % NU);
        if (!gnt_vld && d_valid[idx]) begin
          gnt_vld = 1'b1;
          gnt     = idx;
        end
      end
    end else begin
      // Comparing against every legal index keeps s >= N from ever granting.
      for (int unsigned k = 0; k < NU; k++) begin
        if (s == SW'(k) && d_valid[k]) begin
          gnt_vld = 1'b1;
          gnt     = SW'(k);
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int unsigned k = 0; k < NU; k++) begin
      if (gnt == SW'(k)) gnt_data = d[k*W +: W];
    end
  end

  // Ready never depends on itself: only on valid, select, mode, ptr and
  // the output-side handshake. Held low while reset is asserted.
  always_comb begin
    d_ready = '0;
    for (int unsigned k = 0; k < NU; k++) begin
      d_ready[k] = rst_n && gnt_vld && load && (gnt == SW'(k));
    end
  end

  always_comb begin
    o_d   = o_q;
    ch_d  = ch_q;
    ptr_d = ptr_q;
    vld_d = vld_q;
    if (load) begin
      if (gnt_vld) begin
        o_d   = gnt_data;
        ch_d  = gnt;
        ptr_d = gnt;
        vld_d = 1'b1;
      end else begin
        vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q   <= '0;
      ch_q  <= '0;
      ptr_q <= SW'(NU - 1);
      vld_q <= 1'b0;
    end else begin
      o_q   <= o_d;
      ch_q  <= ch_d;
      ptr_q <= ptr_d;
      vld_q <= vld_d;
    end
  end

  assign o       = o_q;
  assign o_ch    = ch_q;
  assign o_valid = vld_q;

endmodule

// File: tb/tb_rr_mux8.sv
// Directed self-checking bench for rr_mux8: one N=8 instance and one
// N=5 instance (non-power-of-2 select range), both W=8.
module tb_rr_mux8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // N=8 instance
  logic        rst_n;
  logic        mode;
  logic [2:0]  s;
  logic [63:0] d;
  logic [7:0]  dv;
  logic [7:0]  drdy;
  logic [7:0]  o;
  logic        ovld;
  logic        ordy;
  logic [2:0]  och;

  // N=5 instance
  logic        rst5_n;
  logic        mode5;
  logic [2:0]  s5;
  logic [39:0] d5;
  logic [4:0]  dv5;
  logic [4:0]  drdy5;
  logic [7:0]  o5;
  logic        ovld5;
  logic        ordy5;
  logic [2:0]  och5;

  int checks   = 0;
  int failures = 0;

  rr_mux8 #(.N(8), .W(8)) u8 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .s(s), .d(d), .d_valid(dv),
    .d_ready(drdy), .o(o), .o_valid(ovld), .o_ready(ordy), .o_ch(och)
  );

  rr_mux8 #(.N(5), .W(8)) u5 (
    .clk(clk), .rst_n(rst5_n), .mode(mode5), .s(s5), .d(d5), .d_valid(dv5),
    .d_ready(drdy5), .o(o5), .o_valid(ovld5), .o_ready(ordy5), .o_ch(och5)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_rr[4];
    exp_rr[0] = 2; exp_rr[1] = 5; exp_rr[2] = 2; exp_rr[3] = 5;

    rst_n = 1'b0; mode = 1'b1; s = 3'd0; dv = 8'hFF; ordy = 1'b1;
    for (int k = 0; k < 8; k++) d[k*8 +: 8] = 8'(8'h10 + k);
    rst5_n = 1'b0; mode5 = 1'b0; s5 = 3'd6; dv5 = 5'h1F; ordy5 = 1'b1;
    for (int k = 0; k < 5; k++) d5[k*8 +: 8] = 8'(8'h20 + k);

    // Reset values
    #12;
    check("rst_o",      32'(o),    32'h0);
    check("rst_och",    32'(och),  32'h0);
    check("rst_ovalid", 32'(ovld), 32'h0);
    check("rst_dready", 32'(drdy), 32'h0);

    @(negedge clk) rst_n = 1'b1;
    #1;
    check("first_dready", 32'(drdy), 32'h01);

    // Mode 1 rotation, all valid
    for (int i = 0; i < 16; i++) begin
      step();
      check("rot_ovalid", 32'(ovld), 32'h1);
      check("rot_och",    32'(och),  32'(i % 8));
      check("rot_o",      32'(o),    32'(8'h10 + i % 8));
    end

    // Two requesters alternate
    dv = 8'b0010_0100;
    for (int i = 0; i < 4; i++) begin
      step();
      check("alt_och", 32'(och), 32'(exp_rr[i]));
      check("alt_o",   32'(o),   32'(8'h10 + exp_rr[i]));
    end

    // Reset mid-stream while a word is pending
    dv = 8'hFF; ordy = 1'b0;
    check("pre_rst_ovalid", 32'(ovld), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ovalid", 32'(ovld), 32'h0);
    check("mid_rst_o",      32'(o),    32'h0);
    check("mid_rst_och",    32'(och),  32'h0);
    check("mid_rst_dready", 32'(drdy), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("post_rst_dready", 32'(drdy), 32'h01);

    // Backpressure: first word from ch0, then held
    step();
    check("bp_first_och", 32'(och),  32'h0);
    check("bp_first_o",   32'(o),    32'h10);
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_ovalid", 32'(ovld), 32'h1);
      check("bp_och",    32'(och),  32'h0);
      check("bp_o",      32'(o),    32'h10);
      check("bp_dready", 32'(drdy), 32'h0);
    end
    ordy = 1'b1;
    #1;
    check("bp_release_dready", 32'(drdy), 32'h02);
    step();
    check("bp_next_och", 32'(och), 32'h1);
    check("bp_next_o",   32'(o),   32'h11);
    step();
    check("bp_next2_och", 32'(och), 32'h2);

    // Mode 0 fixed select
    mode = 1'b0; s = 3'd5;
    #1;
    check("m0_dready", 32'(drdy), 32'h20);
    for (int i = 0; i < 3; i++) begin
      step();
      check("m0_och", 32'(och), 32'h5);
      check("m0_o",   32'(o),   32'h15);
    end
    s = 3'd6;
    step();
    check("m0_s6_och", 32'(och), 32'h6);
    check("m0_s6_o",   32'(o),   32'h16);

    // Selected channel not valid: word drains, outputs hold
    s = 3'd2; dv = 8'hFB;
    #1;
    check("m0_inv_dready", 32'(drdy), 32'h0);
    step();
    check("m0_inv_ovalid", 32'(ovld), 32'h0);
    check("m0_inv_o",      32'(o),    32'h16);
    check("m0_inv_och",    32'(och),  32'h6);

    // Mode switch with ptr retained
    mode = 1'b1; dv = 8'h08;
    step();
    check("sw_m1_och", 32'(och), 32'h3);
    mode = 1'b0; s = 3'd3; dv = 8'hFF;
    step();
    check("sw_m0_och", 32'(och), 32'h3);
    check("sw_m0_o",   32'(o),   32'h13);
    mode = 1'b1;
    step();
    check("sw_back_och", 32'(och), 32'h4);
    check("sw_back_o",   32'(o),   32'h14);

    // N=5: out-of-range select grants nothing
    @(negedge clk) rst5_n = 1'b1;
    #1;
    check("n5_s6_dready", 32'(drdy5), 32'h0);
    step();
    step();
    check("n5_s6_ovalid", 32'(ovld5), 32'h0);
    s5 = 3'd5;
    #1;
    check("n5_s5_dready", 32'(drdy5), 32'h0);
    step();
    check("n5_s5_ovalid", 32'(ovld5), 32'h0);

    // N=5 round-robin with wrap
    mode5 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      check("n5_rr_ovalid", 32'(ovld5), 32'h1);
      check("n5_rr_och",    32'(och5),  32'(i % 5));
      check("n5_rr_o",      32'(o5),    32'(8'h20 + i % 5));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
